// File: rtl/fwd_pkg.sv
// fwd_pkg: shared defaults, select-width helper and beat record for fwd_sel_pipe.
package fwd_pkg;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NUM_IN = 4;
   function automatic int fwd_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
   // one spare code bit so out-of-range selects stay representable
   localparam int DEF_SEL_W = fwd_clog2(DEF_NUM_IN) + 1;
   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic                 sel_err;
   } beat_t;
endpackage

// File: rtl/fwd_skid_buf.sv
// fwd_skid_buf: generic two-entry valid/ready skid buffer with a registered in_ready.
// FWD_SEL_PIPE_BYPASS_EN: an empty buffer with out_ready high passes the beat through combinationally.
module fwd_skid_buf #(
   parameter int DW = 33
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_beat,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_beat
);
   logic          m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   logic [DW-1:0] m_q, m_d, s_q, s_d;
   logic          accept, bypass;
   assign accept = in_valid && !s_valid_q;
`ifdef FWD_SEL_PIPE_BYPASS_EN
   assign bypass = accept && !m_valid_q && out_ready;
`else
   assign bypass = 1'b0;
`endif
   assign in_ready  = !s_valid_q;
   assign out_valid = m_valid_q || bypass;
   assign out_beat  = bypass ? in_beat : m_q;
   // S full implies M full and in_ready low, so no accept can collide with the S->M move
   always_comb begin
      m_valid_d = m_valid_q;
      m_d       = m_q;
      s_valid_d = s_valid_q;
      s_d       = s_q;
      if (s_valid_q) begin
         if (out_ready) begin
            m_d       = s_q;
            s_valid_d = 1'b0;
         end
      end else if (accept && !bypass) begin
         if (!m_valid_q || out_ready) begin
            m_valid_d = 1'b1;
            m_d       = in_beat;
         end else begin
            s_valid_d = 1'b1;
            s_d       = in_beat;
         end
      end else if (out_ready) begin
         m_valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_q       <= '0;
         s_q       <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_q       <= m_d;
         s_q       <= s_d;
      end
   end
endmodule

// File: rtl/fwd_sel_pipe.sv
// fwd_sel_pipe: NUM_IN-way operand-forwarding select, registered through a 2-entry skid buffer.
// FWD_SEL_PIPE_BYPASS_EN (in fwd_skid_buf) adds 0-cycle pass-through when the pipe is empty.
module fwd_sel_pipe
   import fwd_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_sel_err,
   output logic                    err_sticky
);
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             sel_err;
   } beat_w_t;
   beat_w_t          in_beat, out_beat;
   logic [WIDTH-1:0] sel_data;
   logic             sel_err, err_q, err_d;
   // out-of-range codes fall back to the last source
   always_comb begin
      sel_err  = int'(in_sel) >= NUM_IN;
      sel_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
      for (int k = 0; k < NUM_IN - 1; k++) if (int'(in_sel) == k) sel_data = in_data[k*WIDTH +: WIDTH];
   end
   assign in_beat = '{data: sel_data, sel_err: sel_err};
   assign err_d   = err_q || (in_valid && in_ready && sel_err);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   fwd_skid_buf #(.DW($bits(beat_w_t))) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_beat   (in_beat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_beat  (out_beat)
   );
   assign out_data    = out_beat.data;
   assign out_sel_err = out_beat.sel_err;
   assign err_sticky  = err_q;
endmodule
